// File: rtl/cpu_drv_pkg.sv
// Shared definitions for the CPU command driver: FSM states, command word layout
// and CPU opcode field positions.
package cpu_drv_pkg;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned REG_W  = 3;
    localparam int unsigned OP_W   = 4;
    localparam int unsigned OPC_W  = REG_W + OP_W;

    // Command word {load, reg, op, data, cin}, 17 bits
    localparam int unsigned CIN_POS  = 0;
    localparam int unsigned DATA_LSB = 1;
    localparam int unsigned OP_LSB   = DATA_LSB + DATA_W;
    localparam int unsigned REG_LSB  = OP_LSB + OP_W;
    localparam int unsigned LOAD_POS = REG_LSB + REG_W;
    localparam int unsigned CMD_W    = LOAD_POS + 1;

    // CPU opcode: reg in [6:4], op in [3:0]
    localparam int unsigned OPC_OP_LSB  = 0;
    localparam int unsigned OPC_REG_LSB = OP_W;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_CAPT  = 2'd3
    } drv_state_e;

    function automatic logic [CMD_W-1:0] pack_cmd(
        input logic              load,
        input logic [REG_W-1:0]  rsel,
        input logic [OP_W-1:0]   op,
        input logic [DATA_W-1:0] data,
        input logic              cin
    );
        logic [CMD_W-1:0] w;
        w = '0;
        w[LOAD_POS]             = load;
        w[REG_LSB +: REG_W]     = rsel;
        w[OP_LSB +: OP_W]       = op;
        w[DATA_LSB +: DATA_W]   = data;
        w[CIN_POS]              = cin;
        return w;
    endfunction

endpackage

// File: rtl/cpu_cmd_fifo.sv
// Command queue for the CPU driver: show-ahead synchronous FIFO with full/empty flags.
module cpu_cmd_fifo
    import cpu_drv_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [CMD_W-1:0] wr_data,
    output logic [CMD_W-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [CMD_W-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             push_en;
    logic             pop_en;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign push_en = push && !full;
    assign pop_en  = pop && !empty;
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push_en) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_en) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop_en) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push_en, pop_en})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/cpu_cmd_driver.sv
// Host-side command driver for the 8-register accumulator CPU.
// Optional statistics counters enabled with `define CPU_DRV_STATS_EN.
module cpu_cmd_driver
    import cpu_drv_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4
`ifdef CPU_DRV_STATS_EN
    ,
    parameter int unsigned CNT_W = 16
`endif
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_load,
    input  logic [REG_W-1:0]  cmd_reg,
    input  logic [OP_W-1:0]   cmd_op,
    input  logic [DATA_W-1:0] cmd_data,
    input  logic              cmd_cin,
    output logic [DATA_W-1:0] cpu_data_in,
    output logic [OPC_W-1:0]  cpu_opcode,
    output logic              cpu_load,
    output logic              cpu_ce,
    output logic              cpu_cin,
    input  logic [DATA_W-1:0] cpu_data_out,
    input  logic              cpu_cout,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [DATA_W-1:0] res_data,
    output logic              res_cout,
    output logic              busy
`ifdef CPU_DRV_STATS_EN
    ,
    output logic [CNT_W-1:0]  stat_loads,
    output logic [CNT_W-1:0]  stat_ops
`endif
);

    drv_state_e       state;
    logic [CMD_W-1:0] push_word;
    logic [CMD_W-1:0] head;
    logic             full;
    logic             empty;
    logic             head_load;
    logic             pop_c;

    assign push_word = pack_cmd(cmd_load, cmd_reg, cmd_op, cmd_data, cmd_cin);
    assign head_load = head[LOAD_POS];
    assign cmd_ready = !full;
    assign busy      = !empty || (state != ST_IDLE);

    // An operation must not overwrite an unconsumed result; loads bypass the stall
    assign pop_c = (state == ST_IDLE) && !empty && (head_load || !res_valid);

    cpu_cmd_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (cmd_valid),
        .pop     (pop_c),
        .wr_data (push_word),
        .rd_data (head),
        .full    (full),
        .empty   (empty)
    );

    // Sequencer: one ce pulse per command, ops wait out the CPU OPERATION cycle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= ST_IDLE;
            cpu_ce      <= 1'b0;
            cpu_load    <= 1'b0;
            cpu_cin     <= 1'b0;
            cpu_opcode  <= '0;
            cpu_data_in <= '0;
            res_valid   <= 1'b0;
            res_data    <= '0;
            res_cout    <= 1'b0;
        end else begin
            cpu_ce <= 1'b0;
            if (res_valid && res_ready) begin
                res_valid <= 1'b0;
            end
            case (state)
                ST_IDLE: begin
                    if (pop_c) begin
                        state                                 <= ST_ISSUE;
                        cpu_ce                                <= 1'b1;
                        cpu_load                              <= head_load;
                        cpu_cin                               <= head[CIN_POS];
                        cpu_opcode[OPC_REG_LSB +: REG_W]      <= head[REG_LSB +: REG_W];
                        cpu_opcode[OPC_OP_LSB +: OP_W]        <= head[OP_LSB +: OP_W];
                        if (head_load) begin
                            cpu_data_in <= head[DATA_LSB +: DATA_W];
                        end
                    end
                end
                ST_ISSUE: state <= cpu_load ? ST_IDLE : ST_WAIT;
                ST_WAIT:  state <= ST_CAPT;
                ST_CAPT: begin
                    res_data  <= cpu_data_out;
                    res_cout  <= cpu_cout;
                    res_valid <= 1'b1;
                    state     <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef CPU_DRV_STATS_EN
    // Saturating issue counters, sampled on the ce pulse itself
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stat_loads <= '0;
            stat_ops   <= '0;
        end else if (cpu_ce) begin
            if (cpu_load) begin
                if (stat_loads != '1) begin
                    stat_loads <= stat_loads + CNT_W'(1);
                end
            end else begin
                if (stat_ops != '1) begin
                    stat_ops <= stat_ops + CNT_W'(1);
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_cpu_cmd_driver.sv
// Self-checking bench for cpu_cmd_driver paired with a behavioural accumulator CPU.
module tb_cpu_cmd_driver;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid, cmd_ready, cmd_load, cmd_cin;
    logic [2:0] cmd_reg;
    logic [3:0] cmd_op;
    logic [7:0] cmd_data;
    logic [7:0] cpu_data_in;
    logic [6:0] cpu_opcode;
    logic       cpu_load, cpu_ce, cpu_cin;
    logic [7:0] cpu_data_out;
    logic       cpu_cout;
    logic       res_valid, res_ready, res_cout, busy;
    logic [7:0] res_data;
`ifdef CPU_DRV_STATS_EN
    logic [15:0] stat_loads, stat_ops;
`endif

    always #5 clk = ~clk;

    cpu_cmd_driver #(
        .FIFO_DEPTH (4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_load     (cmd_load),
        .cmd_reg      (cmd_reg),
        .cmd_op       (cmd_op),
        .cmd_data     (cmd_data),
        .cmd_cin      (cmd_cin),
        .cpu_data_in  (cpu_data_in),
        .cpu_opcode   (cpu_opcode),
        .cpu_load     (cpu_load),
        .cpu_ce       (cpu_ce),
        .cpu_cin      (cpu_cin),
        .cpu_data_out (cpu_data_out),
        .cpu_cout     (cpu_cout),
        .res_valid    (res_valid),
        .res_ready    (res_ready),
        .res_data     (res_data),
        .res_cout     (res_cout),
        .busy         (busy)
`ifdef CPU_DRV_STATS_EN
        ,
        .stat_loads   (stat_loads),
        .stat_ops     (stat_ops)
`endif
    );

    // Behavioural CPU: ce+load writes a register, ce+op spends one OPERATION cycle
    logic [7:0] cregs [8];
    logic       ccout;
    logic       op_phase;
    logic [2:0] p_reg;
    logic [3:0] p_op;
    logic       p_cin;
    int         ce_in_op = 0;

    function automatic logic [8:0] alu(input logic [7:0] a, input logic [7:0] b,
                                       input logic [3:0] op, input logic cin);
        case (op)
            4'h0:    return {1'b0, a} + {1'b0, b} + 9'(cin);
            4'h1:    return {1'b0, a} + {1'b0, ~b} + 9'(cin);
            4'h2:    return {1'b0, a & b};
            4'h3:    return {1'b0, a | b};
            4'h4:    return {1'b0, a ^ b};
            default: return {1'b0, a};
        endcase
    endfunction

    assign cpu_data_out = cregs[0];
    assign cpu_cout     = ccout;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 8; i++) cregs[i] <= 8'h00;
            ccout    <= 1'b0;
            op_phase <= 1'b0;
        end else if (op_phase) begin
            {ccout, cregs[0]} <= alu(cregs[0], cregs[p_reg], p_op, p_cin);
            op_phase          <= 1'b0;
            if (cpu_ce) ce_in_op <= ce_in_op + 1;
        end else if (cpu_ce) begin
            if (cpu_load) begin
                cregs[cpu_opcode[6:4]] <= cpu_data_in;
            end else begin
                op_phase <= 1'b1;
                p_reg    <= cpu_opcode[6:4];
                p_op     <= cpu_opcode[3:0];
                p_cin    <= cpu_cin;
            end
        end
    end

    // Cycle stamps of ce pulses and res_valid rising edges
    int   cyc = 0;
    int   ce_q[$];
    int   rv_q[$];
    logic rv_d = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (cpu_ce) ce_q.push_back(cyc);
        if (res_valid && !rv_d) rv_q.push_back(cyc);
        rv_d <= res_valid;
    end

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic push(input logic ld, input logic [2:0] r, input logic [3:0] op,
                        input logic [7:0] d, input logic ci);
        int n;
        n = 0;
        cmd_valid = 1'b1;
        cmd_load  = ld;
        cmd_reg   = r;
        cmd_op    = op;
        cmd_data  = d;
        cmd_cin   = ci;
        while (!cmd_ready && n < 50) begin
            tick();
            n++;
        end
        chk("push_ready", 32'(cmd_ready), 32'd1);
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic wait_res(input string nm);
        int n;
        n = 0;
        while (!res_valid && n < 20) begin
            tick();
            n++;
        end
        chk(nm, 32'(res_valid), 32'd1);
    endtask

    task automatic accept();
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
    endtask

    typedef struct {
        logic       ld;
        logic [2:0] r;
        logic [3:0] op;
        logic [7:0] d;
        logic       ci;
        logic [7:0] ed;
        logic       ec;
    } vec_t;

    vec_t tbl[14];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required finish before 200000");
        $fatal(1);
    end

    initial begin
        int base, rbase, n0, n1, n;

        tbl[0]  = '{1'b1, 3'd0, 4'h0, 8'h12, 1'b0, 8'h00, 1'b0};
        tbl[1]  = '{1'b1, 3'd1, 4'h0, 8'h34, 1'b0, 8'h00, 1'b0};
        tbl[2]  = '{1'b0, 3'd1, 4'h0, 8'h00, 1'b0, 8'h46, 1'b0};
        tbl[3]  = '{1'b1, 3'd2, 4'h0, 8'hF0, 1'b0, 8'h00, 1'b0};
        tbl[4]  = '{1'b0, 3'd2, 4'h0, 8'h00, 1'b1, 8'h37, 1'b1};
        tbl[5]  = '{1'b0, 3'd1, 4'h2, 8'h00, 1'b0, 8'h34, 1'b0};
        tbl[6]  = '{1'b0, 3'd2, 4'h3, 8'h00, 1'b0, 8'hF4, 1'b0};
        tbl[7]  = '{1'b0, 3'd1, 4'h4, 8'h00, 1'b0, 8'hC0, 1'b0};
        tbl[8]  = '{1'b1, 3'd3, 4'h0, 8'h01, 1'b0, 8'h00, 1'b0};
        tbl[9]  = '{1'b0, 3'd3, 4'h1, 8'h00, 1'b1, 8'hBF, 1'b1};
        tbl[10] = '{1'b0, 3'd3, 4'h1, 8'h00, 1'b0, 8'hBD, 1'b1};
        tbl[11] = '{1'b1, 3'd0, 4'h0, 8'h00, 1'b0, 8'h00, 1'b0};
        tbl[12] = '{1'b0, 3'd3, 4'h1, 8'h00, 1'b1, 8'hFF, 1'b0};
        tbl[13] = '{1'b0, 3'd0, 4'h0, 8'h00, 1'b1, 8'hFF, 1'b1};

        // Reset held with a command offered
        rst       = 1'b0;
        cmd_valid = 1'b1;
        cmd_load  = 1'b1;
        cmd_reg   = 3'd0;
        cmd_op    = 4'h0;
        cmd_data  = 8'hAA;
        cmd_cin   = 1'b0;
        res_ready = 1'b0;
        repeat (3) tick();
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("rst_cpu_ce", 32'(cpu_ce), 32'd0);
        chk("rst_res_valid", 32'(res_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_res_data", 32'(res_data), 32'd0);
        cmd_valid = 1'b0;
        rst       = 1'b1;
        repeat (2) tick();

        // Load, load, op: ce spacing and result latency
        base  = ce_q.size();
        rbase = rv_q.size();
        push(1'b1, 3'd0, 4'h0, 8'h12, 1'b0);
        push(1'b1, 3'd1, 4'h0, 8'h34, 1'b0);
        push(1'b0, 3'd1, 4'h0, 8'h00, 1'b0);
        wait_res("lat_res_valid");
        chk("lat_res_data", 32'(res_data), 32'h46);
        chk("lat_res_cout", 32'(res_cout), 32'd0);
        chk("lat_ce_count", 32'(ce_q.size() - base), 32'd3);
        if (ce_q.size() >= base + 3 && rv_q.size() > rbase) begin
            chk("lat_load_gap", 32'(ce_q[base+1] - ce_q[base]), 32'd2);
            chk("lat_op_gap", 32'(ce_q[base+2] - ce_q[base+1]), 32'd2);
            chk("lat_res_delay", 32'(rv_q[rbase] - ce_q[base+2]), 32'd3);
        end
`ifdef CPU_DRV_STATS_EN
        chk("stat_loads", 32'(stat_loads), 32'd2);
        chk("stat_ops", 32'(stat_ops), 32'd1);
`endif
        accept();

        // Table of commands with hand-computed results
        for (int i = 0; i < 14; i++) begin
            push(tbl[i].ld, tbl[i].r, tbl[i].op, tbl[i].d, tbl[i].ci);
            if (!tbl[i].ld) begin
                wait_res($sformatf("vec%0d_valid", i));
                chk($sformatf("vec%0d_data", i), 32'(res_data), 32'(tbl[i].ed));
                chk($sformatf("vec%0d_cout", i), 32'(res_cout), 32'(tbl[i].ec));
                accept();
            end
        end
        repeat (2) tick();

        // Pending result stalls ops; queue fills and deasserts ready
        push(1'b0, 3'd1, 4'h2, 8'h00, 1'b0);
        wait_res("fill_first_valid");
        for (int i = 0; i < 4; i++) push(1'b0, 3'd1, 4'h0, 8'h00, 1'b0);
        chk("full_ready", 32'(cmd_ready), 32'd0);
        chk("full_busy", 32'(busy), 32'd1);
        n0        = ce_q.size();
        cmd_valid = 1'b1;
        repeat (5) tick();
        chk("stall_ready", 32'(cmd_ready), 32'd0);
        chk("stall_no_ce", 32'(ce_q.size()), 32'(n0));
        chk("stall_res_valid", 32'(res_valid), 32'd1);
        chk("stall_res_hold", 32'(res_data), 32'h34);
        accept();
        push(1'b0, 3'd1, 4'h0, 8'h00, 1'b0);
        repeat (2) tick();
        chk("release_one_ce", 32'(ce_q.size()), 32'(n0 + 1));
        for (int i = 0; i < 5; i++) begin
            wait_res($sformatf("drain%0d_valid", i));
            accept();
        end
        repeat (8) tick();
        chk("drain_busy", 32'(busy), 32'd0);

        // Load queued behind an op issues only after CAPT
        n0 = ce_q.size();
        push(1'b0, 3'd1, 4'h0, 8'h00, 1'b0);
        push(1'b1, 3'd2, 4'h0, 8'h5A, 1'b0);
        n = 0;
        while (ce_q.size() < n0 + 2 && n < 20) begin
            tick();
            n++;
        end
        chk("opload_ce_count", 32'(ce_q.size()), 32'(n0 + 2));
        if (ce_q.size() >= n0 + 2) chk("opload_gap", 32'(ce_q[n0+1] - ce_q[n0]), 32'd4);
        wait_res("opload_res_valid");
        accept();
        tick();
        chk("opload_r2", 32'(cregs[2]), 32'h5A);

        // Reset asserted while the driver sits in WAIT
        n0 = ce_q.size();
        push(1'b0, 3'd1, 4'h0, 8'h00, 1'b0);
        push(1'b1, 3'd3, 4'h0, 8'h77, 1'b0);
        n = 0;
        while (ce_q.size() <= n0 && n < 20) begin
            tick();
            n++;
        end
        tick();
        rst = 1'b0;
        #1;
        chk("rstw_res_valid", 32'(res_valid), 32'd0);
        chk("rstw_busy", 32'(busy), 32'd0);
        chk("rstw_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("rstw_cpu_ce", 32'(cpu_ce), 32'd0);
`ifdef CPU_DRV_STATS_EN
        chk("rstw_stat_loads", 32'(stat_loads), 32'd0);
        chk("rstw_stat_ops", 32'(stat_ops), 32'd0);
`endif
        tick();
        rst = 1'b1;
        n1  = ce_q.size();
        repeat (6) tick();
        chk("rstw_flushed_ce", 32'(ce_q.size()), 32'(n1));
        chk("rstw_no_result", 32'(res_valid), 32'd0);
        chk("rstw_idle_busy", 32'(busy), 32'd0);

        chk("ce_during_operation", 32'(ce_in_op), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
